// File: rtl/group_split_pkg.sv
// group_split_pkg: shared constants for the grouping protocol.
// Holds the default geometry, the width derivations of the packed output
// entry and its field offsets. The re-grouping stage imports the same
// package, so both ends agree on the entry layout:
//   entry = {zero[ZERO_INFO-1:0], rep[REP_INFO-1:0], value[DATA_WIDTH-1:0]}
// Also holds the load/emit FSM state type.
package group_split_pkg;

    localparam int DEF_GROUP_SIZE     = 4;
    localparam int DEF_LOG_GROUP_SIZE = 2;
    localparam int DEF_DATA_WIDTH     = 16;

    function automatic int rep_info(input int group_size);
        return group_size * group_size;
    endfunction

    function automatic int zero_info(input int group_size);
        return group_size;
    endfunction

    function automatic int output_width(input int group_size, input int data_width);
        return data_width + rep_info(group_size) + zero_info(group_size);
    endfunction

    localparam int REP_INFO     = rep_info(DEF_GROUP_SIZE);
    localparam int ZERO_INFO    = zero_info(DEF_GROUP_SIZE);
    localparam int OUTPUT_WIDTH = output_width(DEF_GROUP_SIZE, DEF_DATA_WIDTH);

    // Field offsets inside the packed entry
    localparam int VALUE_LSB = 0;
    localparam int REP_LSB   = DEF_DATA_WIDTH;
    localparam int ZERO_LSB  = DEF_DATA_WIDTH + REP_INFO;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT
    } state_t;

endpackage

// File: rtl/group_split_if.sv
// group_split_if: upstream group write and downstream entry stream.
//   data_in   : GROUP_SIZE*DATA_WIDTH group, position i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_in  : group write strobe
//   avail_out : upstream may write
//   data_out  : packed entry {zero, rep, value}
//   valid_out : entry valid (a transfer whenever asserted)
//   avail_in  : downstream has space
// master = environment side (source of groups, sink of entries),
// slave  = group_split side.
interface group_split_if
    import group_split_pkg::*;
#(
    parameter int GROUP_SIZE = DEF_GROUP_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int OUT_W = output_width(GROUP_SIZE, DATA_WIDTH);

    logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in;
    logic                             valid_in;
    logic                             avail_out;
    logic [OUT_W-1:0]                 data_out;
    logic                             valid_out;
    logic                             avail_in;

    modport master (
        output data_in, valid_in, avail_in,
        input  avail_out, data_out, valid_out
    );

    modport slave (
        input  data_in, valid_in, avail_in,
        output avail_out, data_out, valid_out
    );
endinterface

// File: rtl/group_split_fifo.sv
// group_split_fifo: small show-ahead FIFO holding whole groups.
// Ports: clk, rst (async, active-low), write/data_in, read/data_out
// (data_out is the current head), empty, full, almost_full (one slot left).
// Writes while full and reads while empty are ignored.
module group_split_fifo #(
    parameter int WIDTH         = 64,
    parameter int NUM_SLOTS     = 4,
    parameter int LOG_NUM_SLOTS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             almost_full
);
    logic [WIDTH-1:0]         mem [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] wr_ptr, rd_ptr;
    logic [LOG_NUM_SLOTS:0]   count;
    logic                     wr_en, rd_en;

    assign wr_en       = write && !full;
    assign rd_en       = read && !empty;
    assign empty       = (count == '0);
    assign full        = (count == (LOG_NUM_SLOTS+1)'(NUM_SLOTS));
    assign almost_full = (count == (LOG_NUM_SLOTS+1)'(NUM_SLOTS - 1));
    assign data_out    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/group_split.sv
// group_split: transmitter side of the grouping protocol. Each group of
// GROUP_SIZE values becomes one entry per distinct representative value,
// every entry carrying the group's repetition matrix and zero vector.
// Ports: clk, rst (async, active-low), configure/num_iters/num_reads_per_iter
// (counter load + enable), bus (group_split_if.slave: group in, entries out).
// Build option: RTLINF_ZERO_SKIP_EN flags zeros in the zero vector and never
// represents them; undefined, zero is an ordinary value and zero stays 0.
module group_split
    import group_split_pkg::*;
#(
    parameter int GROUP_SIZE             = DEF_GROUP_SIZE,
    parameter int LOG_GROUP_SIZE         = DEF_LOG_GROUP_SIZE,
    parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    group_split_if.slave                      bus
);
    localparam int REP_W  = rep_info(GROUP_SIZE);
    localparam int ZERO_W = zero_info(GROUP_SIZE);
    localparam int GRP_W  = GROUP_SIZE * DATA_WIDTH;

    state_t                            state, state_n;
    logic [GRP_W-1:0]                  head, grp_r;
    logic [REP_W-1:0]                  rep_c, rep_r;
    logic [ZERO_W-1:0]                 zero_c, zero_r;
    logic [GROUP_SIZE-1:0]             diag_c, pend_r, pend_next;
    logic [LOG_GROUP_SIZE-1:0]         sel;
    logic                              found;
    logic                              empty, full, almost_full, pop;
    logic                              fire, done;
    logic                              enabled_r, enabled_n;
    logic [LOG_MAX_ITERS-1:0]          iters_r, iters_n;
    logic [LOG_MAX_READS_PER_ITER-1:0] reads_r, reads_n, reads_copy_r;

    group_split_fifo #(
        .WIDTH(GRP_W),
        .NUM_SLOTS(4),
        .LOG_NUM_SLOTS(2)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .write(bus.valid_in),
        .data_in(bus.data_in),
        .read(pop),
        .data_out(head),
        .empty(empty),
        .full(full),
        .almost_full(almost_full)
    );

    // Representatives, repetition matrix and zero vector of the FIFO head
    always_comb begin
        zero_c = '0;
        diag_c = '0;
        rep_c  = '0;
        for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
`ifdef RTLINF_ZERO_SKIP_EN
            zero_c[i] = (head[i*DATA_WIDTH +: DATA_WIDTH] == '0);
            diag_c[i] = !zero_c[i];
`else
            diag_c[i] = 1'b1;
`endif
            for (int unsigned j = 0; j < i; j++) begin
                if (head[j*DATA_WIDTH +: DATA_WIDTH] == head[i*DATA_WIDTH +: DATA_WIDTH])
                    diag_c[i] = 1'b0;
            end
        end
        for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
            for (int unsigned j = 0; j < GROUP_SIZE; j++) begin
                rep_c[i*GROUP_SIZE + j] = diag_c[i] &&
                    (head[j*DATA_WIDTH +: DATA_WIDTH] == head[i*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    // Lowest pending representative
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < GROUP_SIZE; i++) begin
            if (pend_r[i] && !found) begin
                sel   = LOG_GROUP_SIZE'(i);
                found = 1'b1;
            end
        end
    end

    assign pend_next = pend_r & (pend_r - 1'b1);
    assign fire      = (state == EMIT) && bus.avail_in;
    assign done      = fire && (pend_next == '0);

    // Counter update; configure takes priority over a group completion
    always_comb begin
        enabled_n = enabled_r;
        iters_n   = iters_r;
        reads_n   = reads_r;
        if (configure) begin
            enabled_n = 1'b1;
            iters_n   = num_iters;
            reads_n   = num_reads_per_iter;
        end else if (done) begin
            if (reads_r == LOG_MAX_READS_PER_ITER'(1)) begin
                if (iters_r == LOG_MAX_ITERS'(1)) begin
                    enabled_n = 1'b0;
                end else begin
                    iters_n = iters_r - 1'b1;
                    reads_n = reads_copy_r;
                end
            end else begin
                reads_n = reads_r - 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: if (!empty && enabled_r) state_n = LOAD;
            LOAD: begin
                pop     = 1'b1;
                state_n = EMIT;
            end
            EMIT: if (done) state_n = (!empty && enabled_n) ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            enabled_r    <= 1'b0;
            iters_r      <= '0;
            reads_r      <= '0;
            reads_copy_r <= '0;
            grp_r        <= '0;
            rep_r        <= '0;
            zero_r       <= '0;
            pend_r       <= '0;
        end else begin
            state     <= state_n;
            enabled_r <= enabled_n;
            iters_r   <= iters_n;
            reads_r   <= reads_n;
            if (configure) reads_copy_r <= num_reads_per_iter;
            if (pop) begin
                grp_r  <= head;
                rep_r  <= rep_c;
                zero_r <= zero_c;
                // No representative means an all-zero group: emit position 0 once
                pend_r <= (diag_c == '0) ? GROUP_SIZE'(1) : diag_c;
            end else if (fire) begin
                pend_r <= pend_next;
            end
        end
    end

    assign bus.valid_out = fire;
    assign bus.data_out  = {zero_r, rep_r, grp_r[sel*DATA_WIDTH +: DATA_WIDTH]};
    assign bus.avail_out = !full && !almost_full && enabled_r;
endmodule

// File: tb/tb_group_split.sv
// tb_group_split: self-checking bench for group_split (G=4, DW=16).
// Table of directed groups, hand-written multi-cycle sequences (stall,
// iteration counters, mid-group reset) and a randomized run checked against
// a queue-based reference model. Follows RTLINF_ZERO_SKIP_EN if defined.
module tb_group_split;
    import group_split_pkg::*;

`ifdef RTLINF_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        configure = 1'b0;
    logic [15:0] num_iters = '0;
    logic [15:0] num_reads = '0;

    group_split_if #(.GROUP_SIZE(4), .DATA_WIDTH(16)) bus ();

    group_split #(
        .GROUP_SIZE(4),
        .LOG_GROUP_SIZE(2),
        .DATA_WIDTH(16),
        .LOG_MAX_ITERS(16),
        .LOG_MAX_READS_PER_ITER(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .configure(configure),
        .num_iters(num_iters),
        .num_reads_per_iter(num_reads),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          proto_err = 0;
    logic [35:0] obs_q[$];
    logic [35:0] exp_q[$];

    typedef struct {
        logic [63:0]       grp;
        int                n;
        logic [3:0][35:0]  e;
    } vec_t;
    vec_t tbl[5];

    always @(negedge clk) begin
        if (bus.valid_out === 1'b1) begin
            obs_q.push_back(bus.data_out);
            if (bus.avail_in !== 1'b1) proto_err++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [35:0] ent(input logic [3:0] z, input logic [15:0] r,
                                        input logic [15:0] v);
        return {z, r, v};
    endfunction

    // Reference: distinct (nonzero when skipping) values in first-seen order
    function automatic void model(input logic [63:0] g);
        logic [15:0] v [4];
        logic [15:0] vals[$];
        int          first[$];
        logic [3:0]  zero;
        logic [15:0] rep;
        zero = '0;
        rep  = '0;
        for (int i = 0; i < 4; i++) v[i] = g[i*16 +: 16];
        for (int i = 0; i < 4; i++) begin
            int idx[$];
            if (ZSKIP && v[i] == 16'd0) begin
                zero[i] = 1'b1;
                continue;
            end
            idx = vals.find_first_index(x) with (x == v[i]);
            if (idx.size() == 0) begin
                vals.push_back(v[i]);
                first.push_back(i);
            end
        end
        foreach (first[k])
            for (int j = 0; j < 4; j++)
                if (v[j] == vals[k]) rep[first[k]*4 + j] = 1'b1;
        if (vals.size() == 0) vals.push_back(16'd0);
        foreach (vals[k]) exp_q.push_back({zero, rep, vals[k]});
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        configure    = 1'b0;
        repeat (2) tick;
        rst = 1'b1;
        tick;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_config(input logic [15:0] it, input logic [15:0] rd);
        num_iters = it;
        num_reads = rd;
        configure = 1'b1;
        tick;
        configure = 1'b0;
    endtask

    task automatic send(input logic [63:0] g, input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!bus.avail_out && n < budget) begin
            tick;
            n++;
        end
        if (bus.avail_out) begin
            bus.data_in  = g;
            bus.valid_in = 1'b1;
            tick;
            bus.valid_in = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic wait_obs(input int want, input int budget);
        int n;
        n = 0;
        while (obs_q.size() < want && n < budget) begin
            tick;
            n++;
        end
    endtask

    task automatic compare_queues(input string name);
        check_val({name, "_count"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            check_val($sformatf("%s_entry%0d", name, k), obs_q[k], exp_q[k]);
    endtask

    initial begin
        bit          ok;
        int          accepted, sent, cyc;
        logic [63:0] g;

        tbl[0].grp = pack4(5, 5, 5, 5); tbl[0].n = 1;
        tbl[0].e[0] = ent(4'b0000, 16'h000F, 16'd5);
        tbl[1].grp = pack4(1, 2, 3, 4); tbl[1].n = 4;
        for (int k = 0; k < 4; k++) tbl[1].e[k] = ent(4'b0000, 16'h8421, 16'(k + 1));
        tbl[2].grp = pack4(0, 7, 0, 7);
        tbl[3].grp = pack4(0, 0, 0, 0); tbl[3].n = 1;
        tbl[4].grp = pack4(3, 0, 3, 9);
`ifdef RTLINF_ZERO_SKIP_EN
        tbl[2].n = 1; tbl[2].e[0] = ent(4'b0101, 16'h00A0, 16'd7);
        tbl[3].e[0] = ent(4'b1111, 16'h0000, 16'd0);
        tbl[4].n = 2;
        tbl[4].e[0] = ent(4'b0010, 16'h8005, 16'd3);
        tbl[4].e[1] = ent(4'b0010, 16'h8005, 16'd9);
`else
        tbl[2].n = 2;
        tbl[2].e[0] = ent(4'b0000, 16'h00A5, 16'd0);
        tbl[2].e[1] = ent(4'b0000, 16'h00A5, 16'd7);
        tbl[3].e[0] = ent(4'b0000, 16'h000F, 16'd0);
        tbl[4].n = 3;
        tbl[4].e[0] = ent(4'b0000, 16'h8025, 16'd3);
        tbl[4].e[1] = ent(4'b0000, 16'h8025, 16'd0);
        tbl[4].e[2] = ent(4'b0000, 16'h8025, 16'd9);
`endif

        bus.data_in  = '0;
        bus.valid_in = 1'b0;
        bus.avail_in = 1'b1;
        rst          = 1'b0;
        repeat (2) tick;
        check_val("reset_valid_out", bus.valid_out, 1'b0);
        check_val("reset_data_out", bus.data_out, 36'd0);
        check_val("reset_avail_out", bus.avail_out, 1'b0);
        rst = 1'b1;
        tick;
        check_val("unconfigured_avail_out", bus.avail_out, 1'b0);
        do_config(16'd1, 16'hFFFF);
        check_val("configured_avail_out", bus.avail_out, 1'b1);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            obs_q.delete();
            send(tbl[i].grp, 20, ok);
            check_val($sformatf("tbl%0d_accept", i), ok, 1'b1);
            if (i == 0) begin
                tick;
                check_val("latency_load_cycle", bus.valid_out, 1'b0);
                tick;
                check_val("latency_first_valid", bus.valid_out, 1'b1);
            end
            wait_obs(tbl[i].n, 50);
            repeat (6) tick;
            check_val($sformatf("tbl%0d_count", i), obs_q.size(), tbl[i].n);
            for (int k = 0; k < tbl[i].n && k < obs_q.size(); k++)
                check_val($sformatf("tbl%0d_entry%0d", i, k), obs_q[k], tbl[i].e[k]);
        end

        // Downstream stall after the second entry
        obs_q.delete();
        exp_q.delete();
        model(pack4(1, 2, 3, 4));
        send(pack4(1, 2, 3, 4), 20, ok);
        wait_obs(2, 30);
        check_val("stall_reach_second", obs_q.size(), 2);
        bus.avail_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check_val($sformatf("stall_valid_low%0d", k), bus.valid_out, 1'b0);
        end
        check_val("stall_hold_count", obs_q.size(), 2);
        bus.avail_in = 1'b1;
        wait_obs(4, 30);
        repeat (6) tick;
        compare_queues("stall");

        // Iteration counters: 2 iterations of 2 groups, 5 offered
        do_reset;
        do_config(16'd2, 16'd2);
        accepted = 0;
        for (int k = 0; k < 5; k++) begin
            g = pack4(16'(k + 1), 16'(k + 1), 16'(k + 1), 16'(k + 1));
            send(g, 30, ok);
            if (ok) begin
                if (accepted < 4) model(g);
                accepted++;
            end
        end
        check_val("iters_accepted_min4", accepted >= 4, 1'b1);
        repeat (60) tick;
        compare_queues("iters");
        check_val("iters_avail_off", bus.avail_out, 1'b0);

        // Reset in the middle of a group
        do_reset;
        do_config(16'd1, 16'd100);
        send(pack4(1, 2, 3, 4), 20, ok);
        cyc = 0;
        while (bus.valid_out !== 1'b1 && cyc < 20) begin
            tick;
            cyc++;
        end
        tick;
        check_val("midrst_pre_valid", bus.valid_out, 1'b1);
        rst = 1'b0;
        #1;
        check_val("midrst_valid_out", bus.valid_out, 1'b0);
        check_val("midrst_data_out", bus.data_out, 36'd0);
        check_val("midrst_avail_out", bus.avail_out, 1'b0);
        tick;
        rst = 1'b1;
        obs_q.delete();
        repeat (10) tick;
        check_val("midrst_dropped", obs_q.size(), 0);

        // Randomized groups with random downstream back-pressure
        do_reset;
        do_config(16'd1, 16'hFFFF);
        sent = 0;
        cyc  = 0;
        while ((sent < 30 || obs_q.size() < exp_q.size()) && cyc < 3000) begin
            bus.avail_in = ($urandom_range(0, 3) != 0);
            if (sent < 30 && bus.avail_out && $urandom_range(0, 1) == 1) begin
                for (int p = 0; p < 4; p++) begin
                    case ($urandom_range(0, 3))
                        0:       g[p*16 +: 16] = 16'd0;
                        1:       g[p*16 +: 16] = 16'd1;
                        2:       g[p*16 +: 16] = 16'd2;
                        default: g[p*16 +: 16] = 16'hBEEF;
                    endcase
                end
                bus.data_in  = g;
                bus.valid_in = 1'b1;
                model(g);
                sent++;
            end else begin
                bus.valid_in = 1'b0;
            end
            tick;
            cyc++;
        end
        bus.valid_in = 1'b0;
        bus.avail_in = 1'b1;
        repeat (10) tick;
        check_val("rand_no_timeout", cyc < 3000, 1'b1);
        compare_queues("rand");
        check_val("handshake_valid_only_with_avail", proto_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/group_split.md
# group_split

Splits each incoming group of GROUP_SIZE results into a stream of unique values tagged with repetition and zero information. It is the transmitter side of the grouping protocol: it runs upstream of the re-grouping stage, which rebuilds the full group from that stream. Each nonzero distinct value is sent once, which removes redundant work between the two stages. The block holds a small input FIFO and runs a load/emit state machine with valid/avail flow control on both sides.

## Interface
- GROUP_SIZE, 4, values per group
- LOG_GROUP_SIZE, 2, bits to index a group position
- DATA_WIDTH, 16, width of one value
- LOG_MAX_ITERS, 16, width of the iteration counter
- LOG_MAX_READS_PER_ITER, 16, width of the groups-per-iteration counter
- Derived: REP_INFO = GROUP_SIZE*GROUP_SIZE; ZERO_INFO = GROUP_SIZE; OUTPUT_WIDTH = DATA_WIDTH+REP_INFO+ZERO_INFO
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- configure  in  1  load both counters and enable the block
- num_iters  in  LOG_MAX_ITERS  number of iterations
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  groups per iteration
- data_in  in  GROUP_SIZE*DATA_WIDTH  group; position i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- valid_in  in  1  group write
- avail_out  out  1  upstream may write
- data_out  out  OUTPUT_WIDTH  output entry packed as {zero[G-1:0], rep[REP_INFO-1:0], value[DATA_WIDTH-1:0]}
- valid_out  out  1  entry valid
- avail_in  in  1  downstream has space

## Operation
- Input FIFO: 4 slots, width GROUP_SIZE*DATA_WIDTH.
  - write = valid_in.
  - avail_out = ~full & ~almost_full & enabled.
- Zero vector: zero[i] = (value_i == 0).
- Representative: position i is a representative iff it is nonzero and no j<i has value_j == value_i.
- Repetition matrix: bit rep[i*G+j] = 1 iff i is a representative and value_j == value_i.
  - Rows of non-representatives are 0.
  - The diagonal marks the representatives.
- Every entry of a group carries that group's full rep and zero fields. Entries differ only in the value field, which is the representative's value.
- Emission order: representatives in ascending index.
- All-zero group: exactly one entry with value 0, rep 0, zero all 1s.
- FSM states:
  - IDLE → LOAD: FIFO not empty and enabled.
  - LOAD: capture the FIFO head, computed matrix and zero vector; set pending mask = diagonal; pop the FIFO; go to EMIT.
  - EMIT: each cycle avail_in = 1, emit the lowest pending representative and clear its bit.
  - EMIT exit on the last bit: go to LOAD if the FIFO is nonempty and enabled after the count update, else IDLE.
- Counters:
  - configure reloads both counters and sets enabled.
  - Each completed group (last entry emitted) decrements reads.
  - When reads hits 1: if iters is 1, clear enabled; otherwise decrement iters and reload reads from a stored copy.
  - When disabled, no new LOAD happens; a group in EMIT still completes.
- configure during EMIT: counters reload, and the in-flight group still finishes.

## Timing
- Reset values: valid_out = 0, data_out = 0, avail_out = 0 (disabled), FSM = IDLE, counters = 0.
- Latency: group written at edge t is in the FIFO at t+1, loaded at t+2, and the first valid_out is in the cycle after t+2.
- Throughput: one entry per cycle while avail_in = 1. There is one LOAD bubble between groups.
- Handshake: valid_out is asserted only in cycles where avail_in = 1, and each such cycle is a transfer. When avail_in = 0, the output holds with valid_out = 0.
- Reset asserted mid-emission: the FIFO, FSM and counters clear immediately, and remaining entries are dropped.
- FIFO full: avail_out = 0. A write while full is the upstream's error and is not required to be handled.

## Configuration
- RTLINF_ZERO_SKIP_EN defined: behaviour as above. Zeros are flagged in the zero vector and never represented.
- RTLINF_ZERO_SKIP_EN undefined:
  - zero is always 0.
  - 0 is treated as an ordinary value and can be a representative.
  - The all-zero rule becomes a single entry with value 0, rep row 0 all 1s.

## Structure
- Shared package holds the width derivations (REP_INFO, ZERO_INFO, OUTPUT_WIDTH) and the field offsets of the packed entry.
- Those constants must match the re-grouping stage exactly.
- Sub-module: the existing FIFO (NUM_SLOTS 4, LOG_NUM_SLOTS 2).
- The matrix compute is a combinational always block inside this module.

## Test plan
All scenarios use G=4, DW=16 and ZERO_SKIP on unless stated.
- Group {5,5,5,5} → one entry: value 5, rep 0x000F, zero 0000.
- Group {1,2,3,4} → four consecutive entries with values 1,2,3,4, each with rep 0x8421 and zero 0000.
- Group {0,7,0,7} → one entry: value 7, rep 0x00A0, zero 0101.
  - With the macro off: two entries, values 0 then 7, rep 0x00A5, zero 0000.
- Group {0,0,0,0} → one entry: value 0, rep 0, zero 1111.
- Group {1,2,3,4} with avail_in dropped for 3 cycles after the second entry → valid_out low for those 3 cycles, then values 3,4. No loss or duplication.
- configure num_iters=2, num_reads_per_iter=2, then send 5 groups:
  - Exactly 4 groups are emitted.
  - avail_out = 0 after the 4th completes.
  - Reset asserted mid-group clears valid_out in the same cycle.
